rgb_csc_writer: RTL and testbench
=================================

Name: rgb_csc_writer

Overview:
- Final colour stage of the decode path. Consumes a stream of upsampled YUV pixels, converts each to RGB with a 3-stage pipeline, packs the results into 16-bit words, and writes them to the external SRAM RGB segment.
- The VGA unit displays that segment directly.
- SRAM accesses go through the top-level SRAM mux, like the other milestone units.

Parameters:
- BASE_ADDR, 18'd146944: first SRAM word of the RGB segment.
- NUM_PIXELS, 76800: pixels per frame (320x240). Must be even.

Ports:
- clock  in  1  50 MHz system clock.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  level input; a rising edge starts a frame.
- done  out  1  one-cycle pulse after the last SRAM write.
- pix_valid  in  1  Y/U/V inputs hold a valid pixel.
- pix_ready  out  1  pixel accepted on a cycle where pix_valid & pix_ready.
- pix_y, pix_u, pix_v  in  8 each  unsigned pixel components.
- SRAM_address  out  18  registered write address.
- SRAM_write_data  out  16  registered write data.
- SRAM_we_n  out  1  registered active-low write strobe.

Behaviour:
- Clock/reset: one clock (clock). Reset is asynchronous, active-low (resetn).
- Reset values: state S_CSC_IDLE; done=0; pix_ready=0; SRAM_we_n=1; SRAM_address=BASE_ADDR; SRAM_write_data=0; all pipeline valids, counters and phase = 0.
- Start detection: start is registered (start_q). start & ~start_q in S_CSC_IDLE clears the pixel and word counters, sets phase=0, and moves to S_CSC_RUN.
  - A start held high does not retrigger.
  - start edges outside S_CSC_IDLE are ignored.
- S_CSC_RUN, datapath:
  - S1 registers (Y-16, U-128, V-128) as 9-bit signed.
  - S2 registers three 32-bit signed sums:
    - R = 76284*Y' + 104595*V'
    - G = 76284*Y' - 25624*U' - 53281*V'
    - B = 76284*Y' + 132251*U'
  - S3 registers each channel clipped to 8 bits:
    - sum < 0 gives 0;
    - sum >>> 16 > 255 gives 255;
    - otherwise sum[23:16] (truncation, no rounding).
- Flow control:
  - advance = ~s3_valid | pack_take. All stages shift on advance.
  - pix_ready = advance & (accepted < NUM_PIXELS) & state==S_CSC_RUN.
  - Bubbles travel with the pipeline.
- Packer (phase 0,1,2), one SRAM word per cycle:
  - phase0: needs s3_valid. Writes {R0,G0}, saves B0, pack_take=1.
  - phase1: needs s3_valid. Writes {B0,R1}, saves G1/B1, pack_take=1.
  - phase2: writes {G1,B1} unconditionally, pack_take=0.
  - Sustained throughput: 2 pixels per 3 cycles.
- Write timing:
  - A word written at edge t appears on SRAM_* during cycle t+1 with SRAM_we_n=0.
  - SRAM_we_n=1 on any cycle with no write.
  - SRAM_address = BASE_ADDR + word_count. word_count increments once per write.
- Latency: a pixel accepted at edge t is in S3 after edge t+2. Its first word is driven in cycle t+4 if the packer is waiting on it.
- Completion: when word_count reaches 3*NUM_PIXELS/2 (115200):
  - state becomes S_CSC_DONE; done=1 for exactly one cycle; then S_CSC_IDLE.
  - The final write is at 18'h3FFFF. The address must not wrap or be written beyond it.
- Extra pixels: pix_valid after NUM_PIXELS accepted is never acknowledged.
- Asynchronous reset mid-frame: immediately forces the reset values. A partially written frame is abandoned; no further writes occur.
- Simultaneous start edge and reset: reset wins.

Decomposition:
- Shared header/package (define_state.h):
  - csc_state_type {S_CSC_IDLE, S_CSC_RUN, S_CSC_DONE};
  - CSC coefficient constants (76284, 104595, 25624, 53281, 132251);
  - RGB segment base and frame-size constants.
- One sub-module, csc_pipe: the 3-stage datapath with advance input and s3 valid/RGB outputs.
- rgb_csc_writer keeps the FSM, the packer and the SRAM address logic.

Test Plan:
- Black/white pair. Pixels (16,128,128) then (235,128,128). Expected writes: BASE=16'h0000, BASE+1=16'h00FE, BASE+2=16'hFEFE, with SRAM_we_n low only on those 3 cycles.
- Clipping. Pixel (255,128,128) gives RGB FF,FF,FF. Pixel (0,128,128) gives 00,00,00. Pixel (128,255,128) gives B=FF. Pixel (128,128,0) gives R=00. Pixel (128,128,128) gives 82,82,82.
- Backpressure. pix_valid held high for 6 pixels: pix_ready pattern is 1,1,0 repeating once the pipe fills; 9 consecutive writes at BASE..BASE+8.
- Input gaps. pix_valid toggled randomly: written data matches the reference model; no write while the packer waits in phase 0/1.
- Full frame. 76800 pixels: exactly 115200 writes; last address 18'h3FFFF; done high exactly 1 cycle; pix_ready stays 0 afterwards. start held high does not restart; a fresh start edge does.
- Reset mid-frame. resetn low after 1000 pixels: SRAM_we_n=1 and pix_ready=0 immediately. A new start edge begins again at BASE_ADDR.

Source files
------------

// File: rtl/rgb_csc_writer_pkg.sv
// Shared definitions for the RGB colour-space-conversion writer.
// - csc_state_type : writer FSM states
// - CSC_K_*        : 16.16 fixed-point YUV->RGB coefficients
// - CSC_RGB_BASE / CSC_NUM_PIXELS : RGB segment base and frame size
// - csc_clip8      : saturate a 16.16 sum to an 8-bit channel
package rgb_csc_writer_pkg;

  typedef enum logic [1:0] {
    S_CSC_IDLE,
    S_CSC_RUN,
    S_CSC_DONE
  } csc_state_type;

  localparam int signed CSC_K_Y  = 76284;
  localparam int signed CSC_K_RV = 104595;
  localparam int signed CSC_K_GU = 25624;
  localparam int signed CSC_K_GV = 53281;
  localparam int signed CSC_K_BU = 132251;

  localparam logic [17:0] CSC_RGB_BASE   = 18'd146944;
  localparam int          CSC_NUM_PIXELS = 76800;

  // Negative -> 0, integer part above 255 -> 255, else truncate the fraction.
  function automatic logic [7:0] csc_clip8(input logic signed [31:0] sum);
    if (sum < 0) return 8'd0;
    if ((sum >>> 16) > 32'sd255) return 8'hFF;
    return sum[23:16];
  endfunction

endpackage

// File: rtl/rgb_csc_writer_csc_pipe.sv
// csc_pipe: 3-stage YUV->RGB datapath.
// - advance          : all stages shift (bubbles included) when high
// - in_valid, in_y/u/v : pixel entering S1
// - s3_valid, s3_r/g/b : clipped RGB of the pixel sitting in S3
module rgb_csc_writer_csc_pipe
  import rgb_csc_writer_pkg::*;
(
  input  logic       clock,
  input  logic       resetn,
  input  logic       advance,
  input  logic       in_valid,
  input  logic [7:0] in_y,
  input  logic [7:0] in_u,
  input  logic [7:0] in_v,
  output logic       s3_valid,
  output logic [7:0] s3_r,
  output logic [7:0] s3_g,
  output logic [7:0] s3_b
);

  localparam int STAGES = 3;

  logic [STAGES:1]    vld_pipe_q, vld_pipe_d;
  logic signed [8:0]  s1_y_q, s1_u_q, s1_v_q, s1_y_d, s1_u_d, s1_v_d;
  logic signed [31:0] s2_r_q, s2_g_q, s2_b_q, s2_r_d, s2_g_d, s2_b_d;
  logic [7:0]         s3_r_q, s3_g_q, s3_b_q, s3_r_d, s3_g_d, s3_b_d;
  logic signed [31:0] y_w, u_w, v_w;

  always_comb begin
    vld_pipe_d = {vld_pipe_q[STAGES-1:1], in_valid};
    // Offsets remove the video black level / chroma midpoint.
    s1_y_d = $signed({1'b0, in_y}) - 9'sd16;
    s1_u_d = $signed({1'b0, in_u}) - 9'sd128;
    s1_v_d = $signed({1'b0, in_v}) - 9'sd128;
    y_w    = 32'(s1_y_q);
    u_w    = 32'(s1_u_q);
    v_w    = 32'(s1_v_q);
    s2_r_d = CSC_K_Y * y_w + CSC_K_RV * v_w;
    s2_g_d = CSC_K_Y * y_w - CSC_K_GU * u_w - CSC_K_GV * v_w;
    s2_b_d = CSC_K_Y * y_w + CSC_K_BU * u_w;
    s3_r_d = csc_clip8(s2_r_q);
    s3_g_d = csc_clip8(s2_g_q);
    s3_b_d = csc_clip8(s2_b_q);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      vld_pipe_q <= '0;
      s1_y_q <= '0; s1_u_q <= '0; s1_v_q <= '0;
      s2_r_q <= '0; s2_g_q <= '0; s2_b_q <= '0;
      s3_r_q <= '0; s3_g_q <= '0; s3_b_q <= '0;
    end else if (advance) begin
      vld_pipe_q <= vld_pipe_d;
      s1_y_q <= s1_y_d; s1_u_q <= s1_u_d; s1_v_q <= s1_v_d;
      s2_r_q <= s2_r_d; s2_g_q <= s2_g_d; s2_b_q <= s2_b_d;
      s3_r_q <= s3_r_d; s3_g_q <= s3_g_d; s3_b_q <= s3_b_d;
    end
  end

  assign s3_valid = vld_pipe_q[STAGES];
  assign s3_r     = s3_r_q;
  assign s3_g     = s3_g_q;
  assign s3_b     = s3_b_q;

endmodule

// File: rtl/rgb_csc_writer.sv
// rgb_csc_writer: converts a YUV pixel stream to RGB, packs pixel pairs into
// three 16-bit words ({R0,G0},{B0,R1},{G1,B1}) and writes them to the SRAM
// RGB segment starting at BASE_ADDR.
// - clock, resetn        : system clock, async active-low reset
// - start / done         : rising edge starts a frame / 1-cycle completion pulse
// - pix_valid/pix_ready, pix_y/u/v : pixel input handshake
// - SRAM_address / SRAM_write_data / SRAM_we_n : registered SRAM write port
module rgb_csc_writer
  import rgb_csc_writer_pkg::*;
#(
  parameter logic [17:0] BASE_ADDR  = CSC_RGB_BASE,
  parameter int          NUM_PIXELS = CSC_NUM_PIXELS
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        start,
  output logic        done,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic [7:0]  pix_y,
  input  logic [7:0]  pix_u,
  input  logic [7:0]  pix_v,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n
);

  localparam logic [17:0] NPIX   = 18'(NUM_PIXELS);
  localparam logic [17:0] NWORDS = 18'(3 * NUM_PIXELS / 2);

  csc_state_type state_q, state_d;
  logic        start_q;
  logic        done_q, done_d;
  logic [17:0] pix_cnt_q, pix_cnt_d;
  logic [17:0] word_cnt_q, word_cnt_d;
  logic [1:0]  phase_q, phase_d;
  logic [7:0]  b0_q, b0_d, g1_q, g1_d, b1_q, b1_d;
  logic [17:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        we_n_q, we_n_d;

  logic        s3_valid;
  logic [7:0]  s3_r, s3_g, s3_b;
  logic        pack_take, pack_wr, advance, accept, start_edge;
  logic [15:0] pack_word;

  assign start_edge = start & ~start_q & (state_q == S_CSC_IDLE);
  assign advance    = ~s3_valid | pack_take;
  assign pix_ready  = advance & (pix_cnt_q < NPIX) & (state_q == S_CSC_RUN);
  assign accept     = pix_valid & pix_ready;

  rgb_csc_writer_csc_pipe u_csc_pipe (
    .clock    (clock),
    .resetn   (resetn),
    .advance  (advance),
    .in_valid (accept),
    .in_y     (pix_y),
    .in_u     (pix_u),
    .in_v     (pix_v),
    .s3_valid (s3_valid),
    .s3_r     (s3_r),
    .s3_g     (s3_g),
    .s3_b     (s3_b)
  );

  // Packer: phases 0/1 consume a pixel each, phase 2 flushes the saved G1/B1.
  always_comb begin
    phase_d   = phase_q;
    b0_d      = b0_q;
    g1_d      = g1_q;
    b1_d      = b1_q;
    pack_take = 1'b0;
    pack_wr   = 1'b0;
    pack_word = '0;
    if (start_edge) begin
      phase_d = 2'd0;
    end else if (state_q == S_CSC_RUN) begin
      unique case (phase_q)
        2'd0: if (s3_valid) begin
          pack_wr = 1'b1; pack_take = 1'b1;
          pack_word = {s3_r, s3_g};
          b0_d = s3_b; phase_d = 2'd1;
        end
        2'd1: if (s3_valid) begin
          pack_wr = 1'b1; pack_take = 1'b1;
          pack_word = {b0_q, s3_r};
          g1_d = s3_g; b1_d = s3_b; phase_d = 2'd2;
        end
        default: begin
          pack_wr = 1'b1;
          pack_word = {g1_q, b1_q};
          phase_d = 2'd0;
        end
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    done_d     = 1'b0;
    pix_cnt_d  = pix_cnt_q;
    word_cnt_d = word_cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_n_d     = 1'b1;
    unique case (state_q)
      S_CSC_IDLE: if (start_edge) begin
        state_d    = S_CSC_RUN;
        pix_cnt_d  = '0;
        word_cnt_d = '0;
        addr_d     = BASE_ADDR;
      end
      S_CSC_RUN: begin
        if (accept) pix_cnt_d = pix_cnt_q + 18'd1;
        if (pack_wr) begin
          // Address is captured pre-increment, so the last word lands on
          // BASE_ADDR + NWORDS - 1 and the address never advances past it.
          we_n_d     = 1'b0;
          addr_d     = BASE_ADDR + word_cnt_q;
          wdata_d    = pack_word;
          word_cnt_d = word_cnt_q + 18'd1;
          if (word_cnt_q + 18'd1 == NWORDS) state_d = S_CSC_DONE;
        end
      end
      default: begin
        done_d  = 1'b1;
        state_d = S_CSC_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_CSC_IDLE;
      start_q    <= 1'b0;
      done_q     <= 1'b0;
      pix_cnt_q  <= '0;
      word_cnt_q <= '0;
      phase_q    <= 2'd0;
      b0_q       <= '0;
      g1_q       <= '0;
      b1_q       <= '0;
      addr_q     <= BASE_ADDR;
      wdata_q    <= '0;
      we_n_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      start_q    <= start;
      done_q     <= done_d;
      pix_cnt_q  <= pix_cnt_d;
      word_cnt_q <= word_cnt_d;
      phase_q    <= phase_d;
      b0_q       <= b0_d;
      g1_q       <= g1_d;
      b1_q       <= b1_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_n_q     <= we_n_d;
    end
  end

  assign done            = done_q;
  assign SRAM_address    = addr_q;
  assign SRAM_write_data = wdata_q;
  assign SRAM_we_n       = we_n_q;

endmodule

// File: tb/tb_rgb_csc_writer.sv
// Self-checking bench for rgb_csc_writer using a small frame whose last word
// lands on 18'h3FFFF, with a write scoreboard fed on pixel acceptance.
module tb_rgb_csc_writer;

  localparam int          NPIX   = 64;
  localparam int          NWORDS = 96;
  localparam logic [17:0] BASE   = 18'h3FFFF - 18'd95;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        pix_valid = 1'b0;
  logic [7:0]  pix_y = '0, pix_u = '0, pix_v = '0;
  logic        done, pix_ready, SRAM_we_n;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_write_data;

  always #10 clock = ~clock;

  rgb_csc_writer #(.BASE_ADDR(BASE), .NUM_PIXELS(NPIX)) dut (
    .clock           (clock),
    .resetn          (resetn),
    .start           (start),
    .done            (done),
    .pix_valid       (pix_valid),
    .pix_ready       (pix_ready),
    .pix_y           (pix_y),
    .pix_u           (pix_u),
    .pix_v           (pix_v),
    .SRAM_address    (SRAM_address),
    .SRAM_write_data (SRAM_write_data),
    .SRAM_we_n       (SRAM_we_n)
  );

  int checks = 0, errors = 0;
  int cyc = 0;
  logic [33:0] exp_q[$];
  int wr_cyc[$];
  int wr_cnt = 0, done_cnt = 0, done_cyc = 0, frame_wr0 = 0;
  int exp_idx = 0, frame_pix = 0;
  logic [17:0] last_addr = '0;
  bit use_model = 1'b1, have_half = 1'b0;
  logic [23:0] half_rgb = '0;

  always @(posedge clock) cyc++;

  // Write monitor: every write must match the head of the scoreboard.
  always @(negedge clock) begin : mon
    logic [33:0] e;
    if (resetn) begin
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (!SRAM_we_n) begin
        wr_cnt++; wr_cyc.push_back(cyc); last_addr = SRAM_address;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write addr=%h data=%h", SRAM_address, SRAM_write_data);
        end else begin
          e = exp_q.pop_front();
          if ({SRAM_address, SRAM_write_data} !== e) begin
            errors++;
            $display("FAIL write got addr=%h data=%h want addr=%h data=%h",
                     SRAM_address, SRAM_write_data, e[33:16], e[15:0]);
          end
        end
      end
    end
  end

  function automatic logic [7:0] clamp(input longint s);
    longint q;
    if (s < 0) return 8'd0;
    q = s / 65536;
    if (q > 255) return 8'hFF;
    return q[7:0];
  endfunction

  function automatic logic [23:0] ref_rgb(input logic [7:0] y, u, v);
    longint yy, uu, vv;
    yy = longint'(y) - 16; uu = longint'(u) - 128; vv = longint'(v) - 128;
    return {clamp(76284*yy + 104595*vv),
            clamp(76284*yy - 25624*uu - 53281*vv),
            clamp(76284*yy + 132251*uu)};
  endfunction

  task automatic push_word(input logic [15:0] w);
    exp_q.push_back({BASE + 18'(exp_idx), w});
    exp_idx++;
  endtask

  task automatic note_accept(input logic [7:0] y, u, v);
    logic [23:0] c;
    frame_pix++;
    if (!use_model) return;
    c = ref_rgb(y, u, v);
    if (!have_half) begin
      half_rgb = c; have_half = 1'b1;
    end else begin
      push_word({half_rgb[23:16], half_rgb[15:8]});
      push_word({half_rgb[7:0], c[23:16]});
      push_word({c[15:8], c[7:0]});
      have_half = 1'b0;
    end
  endtask

  // Called at a negedge; returns at the negedge after acceptance, valid still high.
  task automatic send_pix(input logic [7:0] y, u, v, output int waits);
    waits = 0;
    pix_valid = 1'b1; pix_y = y; pix_u = u; pix_v = v;
    while (!pix_ready && waits < 50) begin @(negedge clock); waits++; end
    if (!pix_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout got pix_ready=0 want 1");
    end else note_accept(y, u, v);
    @(negedge clock);
  endtask

  task automatic do_start;
    @(negedge clock);
    start = 1'b1; exp_idx = 0; frame_pix = 0; done_cnt = 0; frame_wr0 = wr_cnt; have_half = 1'b0;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_drain;
    int n;
    n = 0; pix_valid = 1'b0;
    while (exp_q.size() != 0 && n < 300) begin @(negedge clock); n++; end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got pending=%0d want 0", exp_q.size());
    end
    repeat (4) @(negedge clock);
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    repeat (3) @(negedge clock);
    checks += 5;
    if (SRAM_we_n !== 1'b1) begin errors++; $display("FAIL rst_we_n got %b want 1", SRAM_we_n); end
    if (pix_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b want 0", pix_ready); end
    if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", done); end
    if (SRAM_address !== BASE) begin errors++; $display("FAIL rst_addr got %h want %h", SRAM_address, BASE); end
    if (SRAM_write_data !== 16'h0) begin errors++; $display("FAIL rst_data got %h want 0", SRAM_write_data); end
    resetn = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if (pix_ready !== 1'b0 || SRAM_we_n !== 1'b1) begin
      errors++; $display("FAIL idle_outputs got ready=%b we_n=%b want 0/1", pix_ready, SRAM_we_n);
    end
  endtask

  task automatic test_black_white;
    int w, n0;
    use_model = 1'b0;
    do_start();
    n0 = wr_cnt;
    push_word(16'h0000); push_word(16'h00FE); push_word(16'hFEFE);
    send_pix(8'd16, 8'd128, 8'd128, w);
    send_pix(8'd235, 8'd128, 8'd128, w);
    wait_drain();
    checks++;
    if (wr_cnt - n0 != 3) begin errors++; $display("FAIL bw_write_count got %0d want 3", wr_cnt - n0); end
  endtask

  task automatic test_clipping;
    int w;
    use_model = 1'b0;
    push_word(16'hFFFF); push_word(16'hFF00); push_word(16'h0000);
    push_word(16'h8250); push_word(16'hFF00); push_word(16'hEA82);
    push_word(16'h8282); push_word(16'h8282); push_word(16'h8282);
    send_pix(8'd255, 8'd128, 8'd128, w);
    send_pix(8'd0,   8'd128, 8'd128, w);
    send_pix(8'd128, 8'd255, 8'd128, w);
    send_pix(8'd128, 8'd128, 8'd0,   w);
    send_pix(8'd128, 8'd128, 8'd128, w);
    send_pix(8'd128, 8'd128, 8'd128, w);
    wait_drain();
    use_model = 1'b1;
  endtask

  task automatic test_backpressure;
    int w, n0;
    int waits[6];
    int want[6] = '{0, 0, 0, 0, 0, 1};
    n0 = wr_cyc.size();
    for (int i = 0; i < 6; i++) begin
      send_pix(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), w);
      waits[i] = w;
    end
    pix_valid = 1'b0;
    wait_drain();
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (waits[i] != want[i]) begin
        errors++; $display("FAIL bp_ready_wait[%0d] got %0d want %0d", i, waits[i], want[i]);
      end
    end
    checks++;
    if (wr_cyc.size() - n0 != 9) begin
      errors++; $display("FAIL bp_write_count got %0d want 9", wr_cyc.size() - n0);
    end else begin
      checks++;
      if (wr_cyc[n0+8] - wr_cyc[n0] != 8) begin
        errors++; $display("FAIL bp_consecutive got span=%0d want 8", wr_cyc[n0+8] - wr_cyc[n0]);
      end
    end
  endtask

  task automatic test_gaps;
    int w;
    for (int i = 0; i < 30; i++) begin
      pix_valid = 1'b0;
      pix_y = 8'($urandom_range(0, 255));
      repeat ($urandom_range(0, 3)) @(negedge clock);
      send_pix(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), w);
    end
    wait_drain();
  endtask

  task automatic test_full_frame;
    int w, rem, acks, n;
    rem = NPIX - frame_pix;
    for (int i = 0; i < rem; i++) begin
      if (i == rem - 2) start = 1'b1;  // held high through completion
      send_pix(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), w);
    end
    // Extra pixel stays offered; it must never be acknowledged.
    acks = 0; n = 0;
    while (done_cnt == 0 && n < 400) begin
      if (pix_ready) acks++;
      @(negedge clock); n++;
    end
    repeat (10) begin
      if (pix_ready) acks++;
      @(negedge clock);
    end
    checks += 6;
    if (acks != 0) begin errors++; $display("FAIL extra_pixel_ack got %0d want 0", acks); end
    if (done_cnt != 1) begin errors++; $display("FAIL done_cycles got %0d want 1", done_cnt); end
    if (wr_cnt - frame_wr0 != NWORDS) begin
      errors++; $display("FAIL frame_writes got %0d want %0d", wr_cnt - frame_wr0, NWORDS);
    end
    if (last_addr !== 18'h3FFFF) begin errors++; $display("FAIL last_addr got %h want 3ffff", last_addr); end
    if (done_cyc <= wr_cyc[$]) begin
      errors++; $display("FAIL done_order got done_cyc=%0d want > %0d", done_cyc, wr_cyc[$]);
    end
    if (exp_q.size() != 0) begin errors++; $display("FAIL frame_pending got %0d want 0", exp_q.size()); end
    checks++;
    if (SRAM_address !== 18'h3FFFF) begin
      errors++; $display("FAIL addr_hold got %h want 3ffff", SRAM_address);
    end
    // Fresh edge restarts at the segment base.
    pix_valid = 1'b0; start = 1'b0;
    do_start();
    checks++;
    if (pix_ready !== 1'b1) begin errors++; $display("FAIL restart_ready got %b want 1", pix_ready); end
    send_pix(8'd100, 8'd90, 8'd200, w);
    send_pix(8'd50, 8'd180, 8'd60, w);
    wait_drain();
    checks++;
    if (last_addr !== BASE + 18'd2) begin
      errors++; $display("FAIL restart_addr got %h want %h", last_addr, BASE + 18'd2);
    end
  endtask

  task automatic test_reset_mid;
    int w, n0;
    resetn = 1'b0; exp_q.delete(); have_half = 1'b0;
    @(negedge clock); resetn = 1'b1;
    do_start();
    for (int i = 0; i < 20; i++)
      send_pix(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), w);
    #2 resetn = 1'b0;
    #1;
    checks += 2;
    if (SRAM_we_n !== 1'b1) begin errors++; $display("FAIL mid_rst_we_n got %b want 1", SRAM_we_n); end
    if (pix_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready got %b want 0", pix_ready); end
    exp_q.delete(); have_half = 1'b0; pix_valid = 1'b0;
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    n0 = wr_cnt;
    repeat (10) @(negedge clock);
    checks++;
    if (wr_cnt != n0) begin errors++; $display("FAIL post_rst_writes got %0d want 0", wr_cnt - n0); end
    do_start();
    send_pix(8'd16, 8'd128, 8'd128, w);
    send_pix(8'd235, 8'd128, 8'd128, w);
    wait_drain();
    checks++;
    if (last_addr !== BASE + 18'd2) begin
      errors++; $display("FAIL mid_restart_addr got %h want %h", last_addr, BASE + 18'd2);
    end
  endtask

  initial begin
    test_reset();
    test_black_white();
    test_clipping();
    test_backpressure();
    test_gaps();
    test_full_frame();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog got timeout want completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

endmodule
